// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache.
//
// Contents:
//   REG_DAT_W    - width of a fetch address (program counter)
//   INS_DAT_W    - width of one instruction word
//   ICACHE_IDX_W - default number of index bits (2**ICACHE_IDX_W one-word lines)
//   state_e      - cache controller states
//   word_align() - clears the byte-offset bits of an address
package icache_pkg;

    localparam int REG_DAT_W    = 32;
    localparam int INS_DAT_W    = 32;
    localparam int ICACHE_IDX_W = 8;

    // IDLE accepts fetches; MISS waits for the memory controller refill.
    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_e;

    function automatic logic [REG_DAT_W-1:0] word_align(input logic [REG_DAT_W-1:0] pc);
        return {pc[REG_DAT_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side handshake bundle of the instruction cache.
//
// Signals (direction as seen by the cache, modport slave):
//   iIF_En  in   fetch request pulse from the fetch stage
//   iIF_Pc  in   fetch address; bits [1:0] are ignored
//   oIF_En  out  reply valid pulse to the fetch stage
//   oIF_Ins out  instruction, valid with oIF_En
//   oMC_En  out  miss read request pulse to the memory controller
//   oMC_Pc  out  word-aligned miss address
//   iMC_En  in   memory controller reply valid pulse
//   iMC_Ins in   refill instruction, valid with iMC_En
//
// modport master is the opposite side (fetch stage plus memory controller).
interface icache_if;

    logic                               iIF_En;
    logic [icache_pkg::REG_DAT_W-1:0]   iIF_Pc;
    logic                               oIF_En;
    logic [icache_pkg::INS_DAT_W-1:0]   oIF_Ins;
    logic                               oMC_En;
    logic [icache_pkg::REG_DAT_W-1:0]   oMC_Pc;
    logic                               iMC_En;
    logic [icache_pkg::INS_DAT_W-1:0]   iMC_Ins;

    modport slave (
        input  iIF_En, iIF_Pc, iMC_En, iMC_Ins,
        output oIF_En, oIF_Ins, oMC_En, oMC_Pc
    );

    modport master (
        output iIF_En, iIF_Pc, iMC_En, iMC_Ins,
        input  oIF_En, oIF_Ins, oMC_En, oMC_Pc
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache with one-word lines.
//
// A fetch pulse in IDLE is looked up combinationally. A hit is answered on
// the next enabled edge. A miss is forwarded to the memory controller as a
// single-word read, and the refill data is written into the line and
// returned to the fetch stage on the same edge it arrives. Only one request
// is outstanding at a time.
//
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset; clears all valid bits
//   en   in   global ready; 0 freezes every register
//   bus  icache_if.slave  fetch and memory-controller handshakes
//
// Parameter:
//   IDX_W  index bits; tag = PC[31:IDX_W+2], index = PC[IDX_W+1:2]
module icache
    import icache_pkg::*;
#(
    parameter int IDX_W = ICACHE_IDX_W
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    icache_if.slave  bus
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = REG_DAT_W - IDX_W - 2;

    state_e                 state_q, state_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [INS_DAT_W-1:0]   data_q [LINES];

    logic                   oif_en_q,  oif_en_d;
    logic [INS_DAT_W-1:0]   oif_ins_q, oif_ins_d;
    logic                   omc_en_q,  omc_en_d;
    logic [REG_DAT_W-1:0]   omc_pc_q,  omc_pc_d;

    logic [IDX_W-1:0]       req_idx;
    logic [TAG_W-1:0]       req_tag;
    logic [IDX_W-1:0]       miss_idx;
    logic [TAG_W-1:0]       miss_tag;
    logic                   hit;
    logic                   fetch_hit;
    logic                   fetch_miss;
    logic                   refill;
    logic                   unused_pc_bits;

    // The byte offset of the fetch address plays no part in the lookup.
    assign unused_pc_bits = ^bus.iIF_Pc[1:0];

    // Lookup of the incoming fetch address.
    assign req_idx = bus.iIF_Pc[IDX_W+1:2];
    assign req_tag = bus.iIF_Pc[REG_DAT_W-1:IDX_W+2];
    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // The miss address register doubles as the latched PC of the pending miss.
    assign miss_idx = omc_pc_q[IDX_W+1:2];
    assign miss_tag = omc_pc_q[REG_DAT_W-1:IDX_W+2];

    assign fetch_hit  = (state_q == IDLE) && bus.iIF_En && hit;
    assign fetch_miss = (state_q == IDLE) && bus.iIF_En && !hit;
    // A memory reply only counts while a miss is pending.
    assign refill     = (state_q == MISS) && bus.iMC_En;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fetches in MISS are ignored, memory replies in IDLE are ignored.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (fetch_miss) state_d = MISS;
            MISS: if (bus.iMC_En) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and valid-bit logic. Reply and request strobes are single-cycle
    // pulses; data and address outputs hold their last value.
    always_comb begin
        oif_en_d  = 1'b0;
        oif_ins_d = oif_ins_q;
        omc_en_d  = 1'b0;
        omc_pc_d  = omc_pc_q;
        valid_d   = valid_q;
        if (fetch_hit) begin
            oif_en_d  = 1'b1;
            oif_ins_d = data_q[req_idx];
        end else if (fetch_miss) begin
            omc_en_d  = 1'b1;
            omc_pc_d  = word_align(bus.iIF_Pc);
        end else if (refill) begin
            oif_en_d          = 1'b1;
            oif_ins_d         = bus.iMC_Ins;
            valid_d[miss_idx] = 1'b1;
        end
    end

    // Output and valid-bit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            oif_en_q  <= 1'b0;
            oif_ins_q <= '0;
            omc_en_q  <= 1'b0;
            omc_pc_q  <= '0;
            valid_q   <= '0;
        end else if (en) begin
            oif_en_q  <= oif_en_d;
            oif_ins_q <= oif_ins_d;
            omc_en_q  <= omc_en_d;
            omc_pc_q  <= omc_pc_d;
            valid_q   <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them.
    // A refill overwrites the line regardless of what it held before.
    always_ff @(posedge clk) begin
        if (!rst && en && refill) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= bus.iMC_Ins;
        end
    end

    assign bus.oIF_En  = oif_en_q;
    assign bus.oIF_Ins = oif_ins_q;
    assign bus.oMC_En  = omc_en_q;
    assign bus.oMC_Pc  = omc_pc_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for the direct-mapped instruction cache.
//
// A behavioural model keeps the cache as a map from line number to the word
// address it currently holds, plus a single pending-miss address, and
// predicts every output each cycle. A compare process checks the DUT against
// it on every falling edge. Directed sequences also check hand-computed
// literal values after each step.
module tb_icache;
    import icache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic en;

    icache_if bus ();

    icache dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit check_on = 1'b0;

    // Behavioural model state.
    logic [31:0] m_line_addr [int];
    logic [31:0] m_line_word [int];
    bit          m_pending;
    logic        exp_if_en;
    logic [31:0] exp_if_ins;
    logic        exp_mc_en;
    logic [31:0] exp_mc_pc;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs starting just after a rising edge, then
    // return one time unit after the following rising edge with pulses cleared.
    task automatic applyStimulus(input logic if_en, input logic [31:0] pc,
                                 input logic mc_en, input logic [31:0] ins);
        bus.iIF_En  = if_en;
        bus.iIF_Pc  = pc;
        bus.iMC_En  = mc_en;
        bus.iMC_Ins = ins;
        @(posedge clk);
        #1;
        bus.iIF_En = 1'b0;
        bus.iMC_En = 1'b0;
    endtask

    function automatic int line_of(input logic [31:0] addr);
        return int'((addr >> 2) % (32'd1 << ICACHE_IDX_W));
    endfunction

    // Model: the cache holds, per line, the word address last refilled there.
    always @(posedge clk) begin
        logic [31:0] aligned;
        int line;
        if (rst) begin
            m_pending = 1'b0;
            m_line_addr.delete();
            m_line_word.delete();
            exp_if_en  = 1'b0;
            exp_if_ins = 32'h0;
            exp_mc_en  = 1'b0;
            exp_mc_pc  = 32'h0;
        end else if (en) begin
            exp_if_en = 1'b0;
            exp_mc_en = 1'b0;
            if (!m_pending && bus.iIF_En) begin
                aligned = bus.iIF_Pc & 32'hFFFF_FFFC;
                line    = line_of(aligned);
                if (m_line_addr.exists(line) && m_line_addr[line] == aligned) begin
                    exp_if_en  = 1'b1;
                    exp_if_ins = m_line_word[line];
                end else begin
                    m_pending = 1'b1;
                    exp_mc_en = 1'b1;
                    exp_mc_pc = aligned;
                end
            end else if (m_pending && bus.iMC_En) begin
                line              = line_of(exp_mc_pc);
                m_line_addr[line] = exp_mc_pc;
                m_line_word[line] = bus.iMC_Ins;
                exp_if_en         = 1'b1;
                exp_if_ins        = bus.iMC_Ins;
                m_pending         = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_on) begin
            checkOutput("cmp_oIF_En",  {31'b0, bus.oIF_En}, {31'b0, exp_if_en});
            checkOutput("cmp_oIF_Ins", bus.oIF_Ins,         exp_if_ins);
            checkOutput("cmp_oMC_En",  {31'b0, bus.oMC_En}, {31'b0, exp_mc_en});
            checkOutput("cmp_oMC_Pc",  bus.oMC_Pc,          exp_mc_pc);
        end
    end

    initial begin
        rst         = 1'b1;
        en          = 1'b1;
        bus.iIF_En  = 1'b0;
        bus.iIF_Pc  = 32'h0;
        bus.iMC_En  = 1'b0;
        bus.iMC_Ins = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        check_on = 1'b1;
        $display("[TB] reset released");

        checkOutput("rst_oIF_En",  {31'b0, bus.oIF_En}, 32'h0);
        checkOutput("rst_oIF_Ins", bus.oIF_Ins,         32'h0);
        checkOutput("rst_oMC_En",  {31'b0, bus.oMC_En}, 32'h0);
        checkOutput("rst_oMC_Pc",  bus.oMC_Pc,          32'h0);

        // Cold miss at address 0.
        applyStimulus(1'b1, 32'h0000_0000, 1'b0, 32'h0);
        checkOutput("t1_mc_en", {31'b0, bus.oMC_En}, 32'h1);
        checkOutput("t1_mc_pc", bus.oMC_Pc,          32'h0000_0000);
        checkOutput("t1_if_en", {31'b0, bus.oIF_En}, 32'h0);

        // Memory answers three cycles after the request.
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0050_0093);
        checkOutput("t2_if_en",  {31'b0, bus.oIF_En}, 32'h1);
        checkOutput("t2_if_ins", bus.oIF_Ins,         32'h0050_0093);
        checkOutput("t2_mc_en",  {31'b0, bus.oMC_En}, 32'h0);

        // Refetch hits with latency one; the reply is a single-cycle pulse.
        applyStimulus(1'b1, 32'h0000_0000, 1'b0, 32'h0);
        checkOutput("t3_if_en",  {31'b0, bus.oIF_En}, 32'h1);
        checkOutput("t3_if_ins", bus.oIF_Ins,         32'h0050_0093);
        checkOutput("t3_mc_en",  {31'b0, bus.oMC_En}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("t3_if_drop", {31'b0, bus.oIF_En}, 32'h0);

        // Same index, new tag: conflict miss; a fetch during MISS is ignored.
        applyStimulus(1'b1, 32'h0000_0400, 1'b0, 32'h0);
        checkOutput("t4_mc_en", {31'b0, bus.oMC_En}, 32'h1);
        checkOutput("t4_mc_pc", bus.oMC_Pc,          32'h0000_0400);
        applyStimulus(1'b1, 32'h0000_0000, 1'b0, 32'h0);
        checkOutput("t4_ign_if", {31'b0, bus.oIF_En}, 32'h0);
        checkOutput("t4_ign_mc", {31'b0, bus.oMC_En}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h1111_1111);
        checkOutput("t4_refill", bus.oIF_Ins, 32'h1111_1111);
        applyStimulus(1'b1, 32'h0000_0002, 1'b0, 32'h0);
        checkOutput("t4_evict_mc", {31'b0, bus.oMC_En}, 32'h1);
        checkOutput("t4_evict_pc", bus.oMC_Pc,          32'h0000_0000);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0050_0093);
        checkOutput("t4_back_ins", bus.oIF_Ins, 32'h0050_0093);

        // A stray memory reply while idle must not write the array.
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hBAD0_BAD0);
        checkOutput("t4_stray_if", {31'b0, bus.oIF_En}, 32'h0);
        applyStimulus(1'b1, 32'h0000_0000, 1'b0, 32'h0);
        checkOutput("t4_stray_hit", bus.oIF_Ins, 32'h0050_0093);

        // Fill line 1, then issue back-to-back hits on consecutive cycles.
        applyStimulus(1'b1, 32'h0000_0004, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00A0_0113);
        applyStimulus(1'b1, 32'h0000_0000, 1'b0, 32'h0);
        checkOutput("b2b_ins0", bus.oIF_Ins, 32'h0050_0093);
        applyStimulus(1'b1, 32'h0000_0004, 1'b0, 32'h0);
        checkOutput("b2b_en1",  {31'b0, bus.oIF_En}, 32'h1);
        checkOutput("b2b_ins1", bus.oIF_Ins,         32'h00A0_0113);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);

        // A stall freezes the reply pulse until the first enabled edge.
        applyStimulus(1'b1, 32'h0000_0000, 1'b0, 32'h0);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
            checkOutput("t5_hold", {31'b0, bus.oIF_En}, 32'h1);
        end
        en = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("t5_drop", {31'b0, bus.oIF_En}, 32'h0);

        // Reset during a miss; the late reply is dropped and valids are gone.
        applyStimulus(1'b1, 32'h0000_0800, 1'b0, 32'h0);
        checkOutput("t6_mc_pc", bus.oMC_Pc, 32'h0000_0800);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        checkOutput("t6_rst_pc", bus.oMC_Pc, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        checkOutput("t6_late_if", {31'b0, bus.oIF_En}, 32'h0);
        applyStimulus(1'b1, 32'h0000_0000, 1'b0, 32'h0);
        checkOutput("t6_remiss_mc", {31'b0, bus.oMC_En}, 32'h1);
        checkOutput("t6_remiss_if", {31'b0, bus.oIF_En}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0050_0093);
        checkOutput("t6_refill", bus.oIF_Ins, 32'h0050_0093);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);

        @(negedge clk);
        check_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
